// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer mode encodings, port indices and the mode-to-port enable decode
package fb_pkg;

    typedef enum logic [4:0] {
        VIEW_FINDER         = 5'd0,
        AUTO_DETECTION_WAIT = 5'd2,
        BLUR_WAIT           = 5'd6,
        SHOW_TRANSFORMED    = 5'd31
    } fb_mode_e;

    localparam int PORT_DISP = 0;
    localparam int PORT_CAM  = 1;
    localparam int PORT_PROC = 2;

    // Bit k set means port k may touch the frame buffer in this mode
    function automatic logic [2:0] port_mask(input logic [4:0] mode);
        port_mask = {mode == AUTO_DETECTION_WAIT || mode == BLUR_WAIT || mode == SHOW_TRANSFORMED,
                     mode == VIEW_FINDER, 1'b1};
    endfunction

endpackage

// File: rtl/fb_read_tag_pipe.sv
// fb_read_tag_pipe: one-hot read tag shift register aligning requester id with memory latency
module fb_read_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] tag_in,
    output logic [2:0] tag_out
);

    logic [DEPTH-1:0][2:0] stage;

    // Shift a tag in every cycle; reset drops everything in flight
    always_ff @(posedge clk or posedge reset)
        if (reset) stage <= '0;
        else stage <= {stage[DEPTH-2:0], tag_in};

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: mode-aware three-port arbiter onto the single-port frame-buffer memory
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int AW       = 19,
    parameter int DW       = 36,
    parameter int RD_LAT   = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      state,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [2:0]    r;
    logic [2:0]    tag_out;
    logic [1:0]    gidx;
    logic [HW-1:0] hold;
    logic          pend;
    logic          ptr_proc;

    // Display wins unless it has starved a waiting enabled camera/processing request too long
    always_comb begin
        r    = req & port_mask(state);
        pend = r[PORT_CAM] | r[PORT_PROC];
        gnt  = (r[PORT_DISP] && !(pend && hold == HW'(MAX_HOLD))) ? 3'b001 :
               (r[PORT_CAM] && (!r[PORT_PROC] || !ptr_proc)) ? 3'b010 :
               r[PORT_PROC] ? 3'b100 : 3'b000;
        gidx = gnt[PORT_PROC] ? 2'd2 : gnt[PORT_CAM] ? 2'd1 : 2'd0;
    end

    // Hold counter and round-robin pointer between camera and processing ports
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hold     <= '0;
            ptr_proc <= 1'b0;
        end else begin
            hold     <= (!pend || gnt[PORT_CAM] || gnt[PORT_PROC]) ? '0 :
                        (gnt[PORT_DISP] && hold != HW'(MAX_HOLD)) ? hold + 1'b1 : hold;
            ptr_proc <= gnt[PORT_CAM] ? 1'b1 : gnt[PORT_PROC] ? 1'b0 : ptr_proc;
        end

    // Register the granted command onto the memory pins; idle cycles never write
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= |gnt && we[gidx];
            if (|gnt) begin
                mem_addr  <= addr[gidx*AW +: AW];
                mem_wdata <= wdata[gidx*DW +: DW];
            end
        end

    fb_read_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (gnt & ~we),
        .tag_out (tag_out)
    );

    // Capture returning memory data alongside the tag of the requester that issued the read
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rvalid <= 3'b000;
            rdata  <= '0;
        end else begin
            rvalid <= tag_out;
            if (|tag_out) rdata <= mem_rdata;
        end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and randomized checks of fb_arbiter against a behavioural model
module tb_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 36;

    logic            clk = 0;
    logic            reset = 1;
    logic [4:0]      st = 5'd0;
    logic [2:0]      req = 3'b000;
    logic [2:0]      we = 3'b000;
    logic [AW-1:0]   a [3] = '{default: '0};
    logic [DW-1:0]   d [3] = '{default: '0};
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [AW-1:0]   a1 = '0, a2 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    assign addr  = {a[2], a[1], a[0]};
    assign wdata = {d[2], d[1], d[0]};

    fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .state     (st),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mf(input logic [AW-1:0] x);
        return {x[16:0], x};
    endfunction

    // Memory returns a function of the address issued RD_LAT cycles earlier
    always @(posedge clk) begin
        a1 <= mem_addr;
        a2 <= a1;
    end
    assign mem_rdata = mf(a2);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model state
    int          hold = 0;
    int          rr_next = 1;
    bit          pv = 0;
    bit          pwe = 0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwd = '0;
    logic [2:0]  exp_rv [8] = '{default: 3'b000};
    logic [DW-1:0] exp_rd [8] = '{default: '0};

    always @(negedge clk) begin
        int s, p;
        bit e1, e2, r0, r1, r2, pend;
        cyc++;
        s = cyc % 8;
        if (reset) begin
            chk("rst_mem_we", 64'(mem_we), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk("rst_rvalid", 64'(rvalid), 64'd0);
            chk("rst_rdata", 64'(rdata), 64'd0);
            hold = 0; rr_next = 1; pv = 0; pwe = 0;
            for (int i = 0; i < 8; i++) exp_rv[i] = 3'b000;
        end else begin
            e1 = (st == 5'd0);
            e2 = (st == 5'd2) || (st == 5'd6) || (st == 5'd31);
            r0 = req[0];
            r1 = req[1] && e1;
            r2 = req[2] && e2;
            pend = r1 || r2;
            if (r0 && !(hold == 15 && pend)) p = 0;
            else if (r1 && r2) p = rr_next;
            else if (r1) p = 1;
            else if (r2) p = 2;
            else p = -1;
            chk("gnt", 64'(gnt), p < 0 ? 64'd0 : 64'(1 << p));
            chk("mem_we", 64'(mem_we), 64'(pwe));
            if (pv) chk("mem_addr", 64'(mem_addr), 64'(paddr));
            if (pwe) chk("mem_wdata", 64'(mem_wdata), 64'(pwd));
            chk("rvalid", 64'(rvalid), 64'(exp_rv[s]));
            if (exp_rv[s] != 0) chk("rdata", 64'(rdata), 64'(exp_rd[s]));
            exp_rv[s] = 3'b000;
            if (p == 1 || p == 2 || !pend) hold = 0;
            else if (p == 0 && hold < 15) hold++;
            if (p == 1) rr_next = 2;
            if (p == 2) rr_next = 1;
            pv = (p >= 0);
            pwe = pv && we[p];
            if (pv) begin
                paddr = a[p];
                pwd = d[p];
                if (!we[p]) begin
                    exp_rv[(cyc + 4) % 8] = 3'(1 << p);
                    exp_rd[(cyc + 4) % 8] = mf(a[p]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 3'b000;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n0, n1, n2;
        logic [4:0] modes [5];
        modes = '{5'd0, 5'd2, 5'd6, 5'd31, 5'd5};
        step(); step();
        reset = 0;
        idle(3);
        // Camera write in view finder
        st = 5'd0; req = 3'b010; we = 3'b010; a[1] = 19'h00010; d[1] = 36'h123456789;
        #3 chk("t1_gnt", 64'(gnt), 64'b010);
        step(); req = 3'b000;
        #3 chk("t1_cmd", {27'(mem_we), 37'({mem_addr[17:0], 19'(mem_wdata[18:0])})},
                 {27'd1, 37'({18'h00010, 19'h56789})});
        chk("t1_wdata", 64'(mem_wdata), 64'h123456789);
        idle(5);
        // Display read returns four cycles after grant
        req = 3'b001; we = 3'b000; a[0] = 19'h00100;
        #3 chk("t2_gnt", 64'(gnt), 64'b001);
        step(); req = 3'b000;
        #3 chk("t2_cmd", {63'(mem_addr), mem_we}, {63'h100, 1'b0});
        step(); step(); step();
        #3 chk("t2_ret", {61'(rdata), rvalid}, {61'h008000100, 3'b001});
        idle(3);
        // Mode masks steer camera vs processing
        st = 5'd6; req = 3'b110; we = 3'b000; n1 = 0; n2 = 0;
        for (int i = 0; i < 10; i++) begin
            #3 n1 += int'(gnt[1]); n2 += int'(gnt[2]);
            step();
        end
        chk("t3_blur_cnt", 64'({n1, n2}), {32'd0, 32'd10});
        st = 5'd0; n1 = 0; n2 = 0;
        for (int i = 0; i < 10; i++) begin
            #3 n1 += int'(gnt[1]); n2 += int'(gnt[2]);
            step();
        end
        chk("t3_vf_cnt", 64'({n1, n2}), {32'd10, 32'd0});
        idle(6);
        reset = 1; step(); reset = 0;
        // Starvation guard: 15 display grants then one processing grant
        st = 5'd31; req = 3'b101; we = 3'b111; n0 = 0; n2 = 0;
        for (int i = 0; i < 32; i++) begin
            #3 n0 += int'(gnt[0]); n2 += int'(gnt[2]);
            if (i == 15 || i == 31) chk("t4_rr_slot", 64'(gnt), 64'b100);
            step();
        end
        chk("t4_cnt", 64'({n0, n2}), {32'd30, 32'd2});
        idle(6);
        // Read survives a mode change; new request is masked immediately
        st = 5'd2; req = 3'b100; we = 3'b000; a[2] = 19'h00055;
        #3 chk("t5_gnt", 64'(gnt), 64'b100);
        step(); st = 5'd0;
        #3 chk("t5_masked", 64'(gnt), 64'b000);
        step(); req = 3'b000; step(); step();
        #3 chk("t5_ret", 64'(rvalid), 64'b100);
        idle(4);
        // Reset drops in-flight reads
        req = 3'b001; we = 3'b000;
        for (int i = 0; i < 3; i++) begin
            a[0] = 19'(i + 1);
            step();
        end
        req = 3'b000; reset = 1;
        step(); reset = 0;
        for (int i = 0; i < 7; i++) begin
            #3 chk("t6_quiet", {62'(rvalid), mem_we}, 64'd0);
            step();
        end
        req = 3'b001; a[0] = 19'h00077;
        step(); req = 3'b000; step(); step(); step();
        #3 chk("t6_ret", {61'(rdata), rvalid}, {61'h003B80077, 3'b001});
        idle(4);
        // Random traffic, mode changes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) st = modes[$urandom_range(0, 4)];
            req = 3'($urandom);
            req[0] = $urandom_range(0, 3) != 0;
            we = 3'($urandom);
            for (int k = 0; k < 3; k++) begin
                a[k] = AW'($urandom);
                d[k] = DW'({$urandom, $urandom});
            end
            reset = $urandom_range(0, 199) == 0;
            step();
        end
        reset = 0;
        idle(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Shares the single-port frame-buffer memory between three requesters: VGA display reader (port 0), camera writer (port 1) and processing engine (port 2: corner detection / blur / transform).
- Sits between those engines and the memory pins.
- Takes the top-level 5-bit mode state so each requester is only serviced in the modes where it is allowed to touch the buffer.
- Tags every read so the returning data reaches the right requester after the fixed memory latency.

Parameters:
AW, 19, address width
DW, 36, data width
RD_LAT, 2, cycles from a registered mem command to valid mem_rdata
MAX_HOLD, 15, max consecutive display grants while another enabled request waits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
state  in  5  top-level mode (0=VIEW_FINDER, 2=AUTO_DETECTION_WAIT, 6=BLUR_WAIT, 31=SHOW_TRANSFORMED)
req  in  3  per-port request, held until granted
we  in  3  per-port write enable (1=write, 0=read)
addr  in  3*AW  per-port address, port k at [k*AW +: AW]
wdata  in  3*DW  per-port write data
gnt  out  3  one-hot accept, combinational, same cycle as request
rvalid  out  3  one-hot read-data-valid, registered
rdata  out  DW  shared read data, registered
mem_addr  out  AW  registered memory address
mem_we  out  1  registered memory write enable
mem_wdata  out  DW  registered memory write data
mem_rdata  in  DW  memory read data

Behaviour:
Reset values:
- mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, rdata=0.
- Round-robin pointer=port1; hold counter=0; tag pipeline cleared.

Enable mask (combinational from state):
- Port 0: always enabled.
- Port 1: enabled only when state==VIEW_FINDER.
- Port 2: enabled only when state is AUTO_DETECTION_WAIT, BLUR_WAIT or SHOW_TRANSFORMED.
- A disabled request is ignored and never granted; no error is flagged.

Arbitration, each cycle, at most one grant:
- Port 0, if requesting, wins. Exception: hold counter == MAX_HOLD and an enabled port 1/2 request is pending; then that cycle goes to the round-robin winner.
- Otherwise, round-robin between ports 1 and 2. The pointer flips to the other port after each port 1/2 grant.

Hold counter:
- Increments on a port 0 grant while an enabled port 1/2 request waits.
- Clears on any port 1/2 grant, or in any cycle where no enabled port 1/2 request waits.
- Saturates at MAX_HOLD.

Command timing, grant in cycle T:
- mem_addr/mem_we/mem_wdata carry the granted request in cycle T+1.
- mem_we=0 in any cycle following a no-grant cycle.

Reads:
- A 3-bit one-hot tag enters a RD_LAT+1 deep shift register.
- In cycle T+2+RD_LAT (T+4 at default), rdata = the registered mem_rdata and rvalid has the tag bit set.
- Writes produce no rvalid.
- Back-to-back reads from any ports pipeline fully: one per cycle, returned in order.

State change mid-operation:
- Reads already granted still return rvalid, even if the port is now disabled.
- New requests follow the new mask from the same cycle.

Reset asserted mid-operation:
- All outputs go to reset values immediately.
- In-flight reads are dropped; no rvalid after reset release until a new grant.

No requests: gnt=0, memory idle (mem_we=0).

Decomposition:
- Shared package fb_pkg: mode encodings (VIEW_FINDER=5'd0, AUTO_DETECTION_WAIT=5'd2, BLUR_WAIT=5'd6, SHOW_TRANSFORMED=5'd31) and port index constants (PORT_DISP=0, PORT_CAM=1, PORT_PROC=2).
- The mode-to-mask decode lives in the package as a function, so the mode machine and the arbiter stay consistent.
- One sub-module: fb_read_tag_pipe, the parameterised RD_LAT+1 stage one-hot tag shift register with async reset.

Test Plan:
1. state=0; port1 write addr=0x00010 data=0x123456789 in cycle 5, no other req -> gnt=3'b010 in cycle 5; cycle 6 mem_we=1, mem_addr=0x00010, mem_wdata=0x123456789; no rvalid ever.
2. state=0; port0 read addr=0x00100 in cycle 10, memory model returns 0xABC -> gnt=3'b001 cycle 10; mem_addr=0x00100, mem_we=0 cycle 11; rvalid=3'b001, rdata=0xABC cycle 14.
3. state=6; ports 1 and 2 requesting continuously, port 0 idle -> port1 never granted; port2 granted every cycle. Switch to state=0 -> port1 granted every cycle, port2 never.
4. state=31; port0 and port2 requesting continuously -> 15 port0 grants, then 1 port2 grant, repeating (period 16).
5. state=2; port2 read granted cycle 20, state changes to 0 in cycle 21 -> rvalid=3'b100 still in cycle 24; port2 new request gets no grant from cycle 21.
6. Reads granted cycles 30-32, reset pulsed cycle 33 -> mem_we=0, rvalid=0 through cycle 40; first grant after release returns normally 4 cycles later.
